// File: rtl/step_ctrl.sv
// step_ctrl: single-step / run-mode execute controller feeding cpu_en to the RISC16 core.
// Optional WAIT-state watchdog is compiled in by defining STEP_WDOG_EN.
module step_ctrl #(
  parameter int CNT_W   = 16,
  parameter int RUN_DIV = 250,
  parameter int TIMEOUT = 1023
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             step_pulse,
  input  logic             run_sw,
  input  logic             halt_in,
  input  logic             instr_done,
  output logic             cpu_en,
  output logic             busy,
  output logic             halted,
  output logic [CNT_W-1:0] step_count,
  output logic             wdog_err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ISSUE  = 2'd1,
    WAIT   = 2'd2,
    HALTED = 2'd3
  } state_t;

  localparam int               DIV_W    = $clog2(RUN_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_DIV - 1);

  if (RUN_DIV < 2 || TIMEOUT < 1) begin : g_param_check
    $error("step_ctrl: RUN_DIV must be >= 2 and TIMEOUT >= 1");
  end

  state_t           state;
  state_t           next_state;
  logic [1:0]       sync_q;
  logic             run_s;
  logic [DIV_W-1:0] div_q;
  logic             run_tick;
  logic             step_req;
  logic             pend_q;
  logic             pend_d;
  logic             count_inc;
  logic             wd_timeout;

  assign run_s    = sync_q[1];
  assign step_req = step_pulse | pend_q | (run_s & run_tick);

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[0], run_sw};
    end
  end

  // run_tick is registered off the divider wrap, so an idle run-mode step is
  // issued RUN_DIV+1 cycles after entering IDLE (period RUN_DIV+3 with a
  // one-cycle completion).
  always_ff @(posedge clk) begin
    if (reset) begin
      div_q    <= '0;
      run_tick <= 1'b0;
    end else if (run_s && state == IDLE) begin
      div_q    <= (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
      run_tick <= (div_q == DIV_LAST);
    end else begin
      div_q    <= '0;
      run_tick <= 1'b0;
    end
  end

`ifdef STEP_WDOG_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);

  logic [WD_W-1:0] wcnt_q;

  assign wd_timeout = (wcnt_q == WD_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      wcnt_q   <= '0;
      wdog_err <= 1'b0;
    end else begin
      if (state == WAIT && !instr_done) begin
        wcnt_q <= wcnt_q + WD_W'(1);
      end else begin
        wcnt_q <= '0;
      end
      if (state == WAIT && !instr_done && wd_timeout) begin
        wdog_err <= 1'b1;
      end
    end
  end
`else
  assign wd_timeout = 1'b0;
  assign wdog_err   = 1'b0;
`endif

  always_comb begin
    next_state = state;
    pend_d     = pend_q;
    count_inc  = 1'b0;
    case (state)
      IDLE: begin
        if (halt_in) begin
          next_state = HALTED;
        end else if (step_req) begin
          next_state = ISSUE;
          pend_d     = 1'b0;
        end
      end
      ISSUE, WAIT: begin
        pend_d = pend_q | step_pulse;
        if (instr_done) begin
          count_inc  = 1'b1;
          next_state = halt_in ? HALTED : IDLE;
        end else if (state == ISSUE) begin
          next_state = WAIT;
        end else if (wd_timeout) begin
          next_state = IDLE;
        end
      end
      HALTED: begin
        pend_d = 1'b0;
        if (!halt_in && step_pulse) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Outputs are registered from next_state so they decode the current state
  // without combinational paths to the core.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      pend_q     <= 1'b0;
      cpu_en     <= 1'b0;
      busy       <= 1'b0;
      halted     <= 1'b0;
      step_count <= '0;
    end else begin
      state  <= next_state;
      pend_q <= pend_d;
      cpu_en <= (next_state == ISSUE);
      busy   <= (next_state == ISSUE) || (next_state == WAIT);
      halted <= (next_state == HALTED);
      if (count_inc) begin
        step_count <= step_count + CNT_W'(1);
      end
    end
  end

endmodule
